// File: rtl/trail_map.sv
// trail_map: owns the game tile map. Sweeps a framed, empty map on restart and
// stamps player trail tiles whenever the controller's player positions move.
package game_pkg;
  localparam int MAP_WIDTH  = 40;
  localparam int MAP_HEIGHT = 30;
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FRAME   = 2'd1,
    PLAYER1 = 2'd2,
    PLAYER2 = 2'd3
  } tile_t;
endpackage

// Per-player write qualifier: decides whether this player's tile lands this cycle.
module trail_lane #(
  parameter int MAP_W = 8,
  parameter int MAP_H = 6,
  parameter int XW    = 3,
  parameter int YW    = 3
) (
  input  game_pkg::tile_t [MAP_W-1:0][MAP_H-1:0] map,
  input  logic          arm,
  input  logic          start,
  input  logic [7:0]    cur_x,
  input  logic [7:0]    cur_y,
  input  logic [7:0]    prev_x,
  input  logic [7:0]    prev_y,
  input  logic          collision,
  output logic          wr,
  output logic [XW-1:0] wx,
  output logic [YW-1:0] wy
);
  logic inb, moved;

  always_comb begin
    inb   = (32'(cur_x) < MAP_W) && (32'(cur_y) < MAP_H);
    moved = (cur_x != prev_x) || (cur_y != prev_y);
    wx    = cur_x[XW-1:0];
    wy    = cur_y[YW-1:0];
    // The game-start stamp lands even though the position has not moved yet.
    wr    = arm && !collision && (start || moved) && inb &&
            (map[wx][wy] != game_pkg::FRAME);
  end
endmodule

module trail_map
  import game_pkg::*;
#(
  parameter int MAP_W = MAP_WIDTH,
  parameter int MAP_H = MAP_HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    selected_player,
  input  logic [7:0]                    current_x_1,
  input  logic [7:0]                    current_y_1,
  input  logic [7:0]                    current_x_2,
  input  logic [7:0]                    current_y_2,
  input  logic                          player1_collision,
  input  logic                          player2_collision,
  output tile_t [MAP_W-1:0][MAP_H-1:0]  map,
  output logic                          map_ready,
  output logic [15:0]                   trail_len_1,
  output logic [15:0]                   trail_len_2
);
  localparam int NP = 2;
  localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam logic [XW-1:0] XMAX = XW'(MAP_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(MAP_H - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, RUN} state_t;
  state_t state;

  logic [XW-1:0]          sx;
  logic [YW-1:0]          sy;
  logic [NP-1:0][7:0]     cur_x, cur_y, prev_x, prev_y;
  logic [NP-1:0]          coll, wr;
  logic [NP-1:0][XW-1:0]  wx;
  logic [NP-1:0][YW-1:0]  wy;
  logic [NP-1:0][15:0]    len;
  logic                   active, arm, same, wr2;

  assign cur_x  = {current_x_2, current_x_1};
  assign cur_y  = {current_y_2, current_y_1};
  assign coll   = {player2_collision, player1_collision};
  assign active = selected_player[0];  // 2'b10 behaves like the menu
  assign arm    = active && (state != CLEAR);

  genvar i;
  generate
    for (i = 0; i < NP; i++) begin : g_lane
      trail_lane #(.MAP_W(MAP_W), .MAP_H(MAP_H), .XW(XW), .YW(YW)) u_lane (
        .map      (map),
        .arm      (arm),
        .start    (state == IDLE),
        .cur_x    (cur_x[i]),
        .cur_y    (cur_y[i]),
        .prev_x   (prev_x[i]),
        .prev_y   (prev_y[i]),
        .collision(coll[i]),
        .wr       (wr[i]),
        .wx       (wx[i]),
        .wy       (wy[i])
      );
    end
  endgenerate

  // Player 1 owns a tile both players reach in the same cycle.
  assign same = wr[0] && wr[1] && (wx[0] == wx[1]) && (wy[0] == wy[1]);
  assign wr2  = wr[1] && !same;

  assign trail_len_1 = len[0];
  assign trail_len_2 = len[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < MAP_W; x++)
        for (int y = 0; y < MAP_H; y++)
          map[x][y] <= EMPTY;
      state     <= CLEAR;
      sx        <= '0;
      sy        <= '0;
      prev_x    <= '0;
      prev_y    <= '0;
      len       <= '0;
      map_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          map[sx][sy] <= (sx == '0 || sx == XMAX || sy == '0 || sy == YMAX) ? FRAME : EMPTY;
          if (sx == XMAX) begin
            sx <= '0;
            if (sy == YMAX) begin
              sy        <= '0;
              state     <= IDLE;
              map_ready <= 1'b1;
            end else begin
              sy <= sy + 1'b1;
            end
          end else begin
            sx <= sx + 1'b1;
          end
        end
        IDLE: begin
          if (active) begin
            state  <= RUN;
            len[0] <= {15'b0, wr[0]};
            len[1] <= {15'b0, wr2};
          end
        end
        RUN: begin
          if (!active) begin
            state     <= CLEAR;
            map_ready <= 1'b0;
            sx        <= '0;
            sy        <= '0;
            len       <= '0;
          end else begin
            if (wr[0] && len[0] != 16'hFFFF) len[0] <= len[0] + 16'd1;
            if (wr2 && len[1] != 16'hFFFF)   len[1] <= len[1] + 16'd1;
          end
        end
        default: state <= CLEAR;
      endcase

      // prev tracks the position even when the write itself is dropped.
      if (arm) begin
        prev_x <= cur_x;
        prev_y <= cur_y;
      end
      if (wr2)   map[wx[1]][wy[1]] <= PLAYER2;
      if (wr[0]) map[wx[0]][wy[0]] <= PLAYER1;
    end
  end
endmodule

// File: tb/tb_trail_map.sv
// Testbench for trail_map: directed game scenarios followed by randomized play,
// all checked against a tile-level reference model of the game map.
module tb_trail_map;
  import game_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [1:0]             sel = 2'b00;
  logic [7:0]             x1 = 8'd0, y1 = 8'd0, x2 = 8'd0, y2 = 8'd0;
  logic                   c1 = 1'b0, c2 = 1'b0;
  tile_t [W-1:0][H-1:0]   map;
  logic                   map_ready;
  logic [15:0]            trail_len_1, trail_len_2;

  trail_map #(.MAP_W(W), .MAP_H(H)) dut (
    .clk              (clk),
    .rst              (rst),
    .selected_player  (sel),
    .current_x_1      (x1),
    .current_y_1      (y1),
    .current_x_2      (x2),
    .current_y_2      (y2),
    .player1_collision(c1),
    .player2_collision(c2),
    .map              (map),
    .map_ready        (map_ready),
    .trail_len_1      (trail_len_1),
    .trail_len_2      (trail_len_2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: whole-map picture, countdown to sweep completion, game flag.
  tile_t [W-1:0][H-1:0] mm;
  bit         m_ready, m_on;
  int         sweep_left, ml1, ml2;
  logic [7:0] p1x, p1y, p2x, p2y;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void fill(input bit framed);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mm[x[2:0]][y[2:0]] = (framed && (x == 0 || x == W-1 || y == 0 || y == H-1)) ? FRAME : EMPTY;
  endfunction

  function automatic bit writable(input logic [7:0] x, input logic [7:0] y);
    if (x >= 8'(W) || y >= 8'(H)) return 1'b0;
    return mm[x[2:0]][y[2:0]] != FRAME;
  endfunction

  task automatic model_step();
    bit w1, w2, start;
    if (rst) begin
      fill(1'b0);
      sweep_left = N; m_ready = 1'b0; m_on = 1'b0; ml1 = 0; ml2 = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0) begin
        fill(1'b1);
        m_ready = 1'b1;
      end
    end else if (m_on && !sel[0]) begin
      m_on = 1'b0; sweep_left = N; m_ready = 1'b0; ml1 = 0; ml2 = 0;
    end else if (sel[0]) begin
      start = !m_on;
      w1 = !c1 && (start || x1 != p1x || y1 != p1y) && writable(x1, y1);
      w2 = !c2 && (start || x2 != p2x || y2 != p2y) && writable(x2, y2);
      if (w1 && w2 && x1 == x2 && y1 == y2) w2 = 1'b0;
      if (w2) mm[x2[2:0]][y2[2:0]] = PLAYER2;
      if (w1) mm[x1[2:0]][y1[2:0]] = PLAYER1;
      if (start) begin
        ml1 = int'(w1);
        ml2 = int'(w2);
      end else begin
        if (w1 && ml1 < 65535) ml1++;
        if (w2 && ml2 < 65535) ml2++;
      end
      p1x = x1; p1y = y1; p2x = x2; p2y = y2;
      m_on = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("map_ready", 128'(map_ready), 128'(m_ready));
    chk("trail_len_1", 128'(trail_len_1), 128'(ml1));
    chk("trail_len_2", 128'(trail_len_2), 128'(ml2));
    if (rst || sweep_left == 0) chk("map", 128'(map), 128'(mm));
  endtask

  task automatic chk_tile(input string tag, input int x, input int y, input tile_t t);
    chk(tag, 128'(map[x[2:0]][y[2:0]]), 128'(t));
  endtask

  initial begin
    int cnt;
    // Reset, then a full 48-cycle sweep.
    rst = 1'b1; tick();
    rst = 1'b0; sel = 2'b00;
    repeat (N) tick();
    chk_tile("frame_0_3", 0, 3, FRAME);
    chk_tile("frame_7_5", 7, 5, FRAME);
    chk_tile("empty_3_2", 3, 2, EMPTY);

    // Game start stamps both players.
    x1 = 8'd2; y1 = 8'd2; x2 = 8'd5; y2 = 8'd3; tick();
    sel = 2'b01; tick();
    chk_tile("start_p1", 2, 2, PLAYER1);
    chk_tile("start_p2", 5, 3, PLAYER2);
    chk("start_len1", 128'(trail_len_1), 128'd1);
    chk("start_len2", 128'(trail_len_2), 128'd1);

    // Trail stamping.
    x1 = 8'd3; tick();
    chk_tile("trail_3_2", 3, 2, PLAYER1);
    y1 = 8'd3; tick();
    chk_tile("trail_3_3", 3, 3, PLAYER1);
    chk_tile("trail_keep_2_2", 2, 2, PLAYER1);
    chk("trail_len1_3", 128'(trail_len_1), 128'd3);

    // Frame target and collision suppress writes.
    x1 = 8'd0; y1 = 8'd2; tick();
    chk_tile("frame_hold", 0, 2, FRAME);
    chk("frame_len1", 128'(trail_len_1), 128'd3);
    c2 = 1'b1; x2 = 8'd4; y2 = 8'd4; tick();
    chk_tile("coll_empty", 4, 4, EMPTY);
    c2 = 1'b0;

    // Same-tile conflict: player 1 wins.
    x1 = 8'd4; y1 = 8'd2; x2 = 8'd4; y2 = 8'd2; tick();
    chk_tile("conflict_p1", 4, 2, PLAYER1);
    chk("conflict_len1", 128'(trail_len_1), 128'd4);
    chk("conflict_len2", 128'(trail_len_2), 128'd1);

    // Restart from RUN, then a reset in the middle of the sweep.
    sel = 2'b00; tick();
    repeat (N) tick();
    chk_tile("restart_clear", 2, 2, EMPTY);
    sel = 2'b11; tick();
    sel = 2'b10; tick();
    repeat (20) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    cnt = 0;
    while (!map_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("rst_sweep_cycles", 128'(cnt), 128'(N));

    // Randomized play with occasional restarts and resets.
    sel = 2'b01;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        x1 = 8'($urandom_range(0, 9)); y1 = 8'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 0) begin
        x2 = 8'($urandom_range(0, 9)); y2 = 8'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) begin
        x2 = x1; y2 = y1;
      end
      if ($urandom_range(0, 63) == 0) x1 = 8'hFF;
      c1 = ($urandom_range(0, 9) == 0);
      c2 = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
